pe_grant_decoder: RTL and testbench



---
 rtl/pe_grant_decoder_pkg.sv | 19 +
 rtl/pe_grant_decoder_if.sv | 34 +++
 rtl/pe_grant_decoder_onehot_dec.sv | 22 ++
 rtl/pe_grant_decoder.sv | 97 +++++++++
 tb/tb_pe_grant_decoder.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pe_grant_decoder_pkg.sv
// ---------------------------------------------------------------------------
// pe_grant_decoder_pkg
//   Shared definitions for the grant decoder. The arbiter's encoder stage uses
//   the same definitions.
//   - state_t          : FSM state encoding (IDLE=0, GRANT=1, RELEASE=2)
//   - PE_IDX_W/PE_N_GNT: default encoded-index width and grant-line count
// ---------------------------------------------------------------------------
package pe_grant_decoder_pkg;

   localparam int PE_IDX_W = 2;
   localparam int PE_N_GNT = 1 << PE_IDX_W;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_GRANT   = 2'd1,
      ST_RELEASE = 2'd2
   } state_t;

endpackage

// File: rtl/pe_grant_decoder_if.sv
// ---------------------------------------------------------------------------
// pe_grant_decoder_if
//   Carries the encoded-request handshake from the encoder into the decoder,
//   and the grant/release signals between the decoder and the requesters.
//   master : encoder + requesters side (drives in_*, ack)
//   slave  : pe_grant_decoder side   (drives in_ready, gnt, busy, timeout_evt)
// ---------------------------------------------------------------------------
interface pe_grant_decoder_if
   import pe_grant_decoder_pkg::*;
#(
   parameter int IDX_W = PE_IDX_W,
   parameter int N_GNT = PE_N_GNT
) ();

   logic             in_valid;
   logic [IDX_W-1:0] in_idx;
   logic             in_none;
   logic             in_ready;
   logic [N_GNT-1:0] ack;
   logic [N_GNT-1:0] gnt;
   logic             busy;
   logic             timeout_evt;

   modport master (
      output in_valid, in_idx, in_none, ack,
      input  in_ready, gnt, busy, timeout_evt
   );

   modport slave (
      input  in_valid, in_idx, in_none, ack,
      output in_ready, gnt, busy, timeout_evt
   );

endinterface

// File: rtl/pe_grant_decoder_onehot_dec.sv
// ---------------------------------------------------------------------------
// pe_onehot_dec
//   Combinational binary-to-one-hot decoder, IDX_W -> N_GNT.
//   i_idx    : binary index
//   o_onehot : exactly one bit set, at position i_idx
// ---------------------------------------------------------------------------
module pe_onehot_dec #(
   parameter int IDX_W = 2,
   parameter int N_GNT = 4
) (
   input  logic [IDX_W-1:0] i_idx,
   output logic [N_GNT-1:0] o_onehot
);

   always_comb begin
      o_onehot = '0;
      for (int i = 0; i < N_GNT; i++) begin
         if (i_idx == IDX_W'(i)) o_onehot[i] = 1'b1;
      end
   end

endmodule

// File: rtl/pe_grant_decoder.sv
// ---------------------------------------------------------------------------
// pe_grant_decoder
//   Consumer side of the 4:2 priority encoder. Takes an encoded winner index
//   over a valid/ready handshake and turns it into a registered one-hot grant.
//   The grant is held until the granted requester acks or the hold timeout
//   expires. A single dead cycle (RELEASE) always follows a grant.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave modport -- in_valid/in_idx/in_none/in_ready handshake,
//           ack per requester, gnt, busy, timeout_evt
// ---------------------------------------------------------------------------
module pe_grant_decoder
   import pe_grant_decoder_pkg::*;
#(
   parameter int IDX_W   = PE_IDX_W,
   parameter int N_GNT   = PE_N_GNT,
   parameter int TIMEOUT = 15,
   parameter int CNT_W   = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   pe_grant_decoder_if.slave  bus
);

   state_t           r_state;
   logic [N_GNT-1:0] r_gnt;
   logic [CNT_W-1:0] r_cnt;
   logic             r_tevt;

   logic [N_GNT-1:0] w_dec;
   logic             w_hit;
   logic             w_expire;

   // Hold counter stops at all-ones; only matters when TIMEOUT=0.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   pe_onehot_dec #(
      .IDX_W (IDX_W),
      .N_GNT (N_GNT)
   ) u_dec (
      .i_idx    (bus.in_idx),
      .o_onehot (w_dec)
   );

   // r_gnt is one-hot while granting, so this picks out ack[g] only;
   // acks on other lines are masked away.
   assign w_hit    = |(r_gnt & bus.ack);
   assign w_expire = (TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_gnt   <= '0;
         r_cnt   <= '0;
         r_tevt  <= 1'b0;
      end else begin
         r_tevt <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               // A "no request" token is consumed without leaving IDLE.
               if (bus.in_valid && !bus.in_none) begin
                  r_gnt   <= w_dec;
                  r_cnt   <= '0;
                  r_state <= ST_GRANT;
               end
            end
            ST_GRANT: begin
               r_cnt <= sat_inc(r_cnt);
               // Ack is checked first so it wins over a coincident expiry.
               if (w_hit) begin
                  r_gnt   <= '0;
                  r_state <= ST_RELEASE;
               end else if (w_expire) begin
                  r_gnt   <= '0;
                  r_tevt  <= 1'b1;
                  r_state <= ST_RELEASE;
               end
            end
            ST_RELEASE: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_gnt   <= '0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready    = (r_state == ST_IDLE);
   assign bus.busy        = (r_state != ST_IDLE);
   assign bus.gnt         = r_gnt;
   assign bus.timeout_evt = r_tevt;

endmodule

// File: tb/tb_pe_grant_decoder.sv
// ---------------------------------------------------------------------------
// tb_pe_grant_decoder
//   Directed scenarios plus a randomized run for pe_grant_decoder, checked
//   against a reference model that tracks "who owns the grant", "how many
//   cycles it has been held" and "is this the dead cycle after a release".
// ---------------------------------------------------------------------------
module tb_pe_grant_decoder;

   localparam int TIMEOUT = 15;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   // Reference model state
   int   m_owner;   // granted requester, -1 when nobody holds the grant
   int   m_age;     // edges since the grant was issued
   bit   m_dead;    // in the gap cycle after a release
   bit   m_tevt;    // timeout pulse expected this cycle

   pe_grant_decoder_if #(.IDX_W(2), .N_GNT(4)) bus ();

   pe_grant_decoder #(
      .IDX_W   (2),
      .N_GNT   (4),
      .TIMEOUT (TIMEOUT),
      .CNT_W   (4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst_n) begin
         assert ($onehot0(bus.gnt))
         else $error("gnt not one-hot-or-zero: %b", bus.gnt);
      end
   end

   function automatic logic [3:0] exp_gnt();
      return (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
   endfunction

   function automatic logic exp_ready();
      return (m_owner < 0) && !m_dead;
   endfunction

   task automatic model_reset();
      m_owner = -1;
      m_age   = 0;
      m_dead  = 1'b0;
      m_tevt  = 1'b0;
   endtask

   // Advance one clock edge and move the model by the same edge, using the
   // inputs that were stable in front of it.
   task automatic tick();
      logic       v, n;
      logic [1:0] idx;
      logic [3:0] a;
      v = bus.in_valid; n = bus.in_none; idx = bus.in_idx; a = bus.ack;
      @(posedge clk);
      #1;
      m_tevt = 1'b0;
      if (m_owner >= 0) begin
         m_age++;
         if (a[m_owner]) begin
            m_owner = -1;
            m_dead  = 1'b1;
         end else if (TIMEOUT != 0 && m_age == TIMEOUT) begin
            m_owner = -1;
            m_dead  = 1'b1;
            m_tevt  = 1'b1;
         end
      end else if (m_dead) begin
         m_dead = 1'b0;
      end else if (v && !n) begin
         m_owner = int'(idx);
         m_age   = 0;
      end
   endtask

   task automatic idle_inputs();
      bus.in_valid = 1'b0;
      bus.in_idx   = 2'd0;
      bus.in_none  = 1'b0;
      bus.ack      = 4'b0000;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (bus.gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt got=%b want=0000", bus.gnt); end
      total++;
      if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", bus.in_ready); end
      total++;
      if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
      total++;
      if (bus.timeout_evt !== 1'b0) begin bad++; $display("FAIL reset_tevt got=%b want=0", bus.timeout_evt); end
      rst_n = 1'b1;
   endtask

   task automatic test_grant_ack();
      bus.in_valid = 1'b1; bus.in_idx = 2'd2; bus.in_none = 1'b0;
      tick();
      bus.in_valid = 1'b0;
      total++;
      if (bus.gnt !== 4'b0100) begin bad++; $display("FAIL grant_gnt got=%b want=0100", bus.gnt); end
      total++;
      if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
         bad++; $display("FAIL grant_busy got busy=%b ready=%b want busy=1 ready=0", bus.busy, bus.in_ready);
      end
      bus.ack = 4'b0100;
      tick();
      bus.ack = 4'b0000;
      total++;
      if (bus.gnt !== 4'b0000 || bus.in_ready !== 1'b0) begin
         bad++; $display("FAIL ack_release got gnt=%b ready=%b want gnt=0000 ready=0", bus.gnt, bus.in_ready);
      end
      total++;
      if (bus.timeout_evt !== 1'b0) begin bad++; $display("FAIL ack_no_tevt got=%b want=0", bus.timeout_evt); end
      tick();
      total++;
      if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
         bad++; $display("FAIL ack_idle got ready=%b busy=%b want ready=1 busy=0", bus.in_ready, bus.busy);
      end
   endtask

   task automatic test_timeout();
      bus.in_valid = 1'b1; bus.in_idx = 2'd0; bus.in_none = 1'b0;
      tick();
      bus.in_valid = 1'b0;
      repeat (TIMEOUT - 1) tick();
      total++;
      if (bus.gnt !== 4'b0001) begin bad++; $display("FAIL timeout_hold got=%b want=0001", bus.gnt); end
      tick();
      total++;
      if (bus.gnt !== 4'b0000 || bus.timeout_evt !== 1'b1) begin
         bad++; $display("FAIL timeout_fire got gnt=%b tevt=%b want gnt=0000 tevt=1", bus.gnt, bus.timeout_evt);
      end
      tick();
      total++;
      if (bus.timeout_evt !== 1'b0 || bus.in_ready !== 1'b1) begin
         bad++; $display("FAIL timeout_pulse got tevt=%b ready=%b want tevt=0 ready=1", bus.timeout_evt, bus.in_ready);
      end
   endtask

   task automatic test_ack_mask();
      bus.in_valid = 1'b1; bus.in_idx = 2'd3; bus.in_none = 1'b0;
      tick();
      bus.in_valid = 1'b0;
      bus.ack = 4'b0111;
      repeat (TIMEOUT - 1) tick();
      total++;
      if (bus.gnt !== 4'b1000) begin bad++; $display("FAIL mask_hold got=%b want=1000", bus.gnt); end
      bus.ack = 4'b1000;
      tick();
      bus.ack = 4'b0000;
      total++;
      if (bus.gnt !== 4'b0000 || bus.timeout_evt !== 1'b0) begin
         bad++; $display("FAIL ack_wins got gnt=%b tevt=%b want gnt=0000 tevt=0", bus.gnt, bus.timeout_evt);
      end
      tick();
   endtask

   task automatic test_none_then_grant();
      bus.in_valid = 1'b1; bus.in_none = 1'b1; bus.in_idx = 2'd3;
      tick();
      total++;
      if (bus.in_ready !== 1'b1 || bus.gnt !== 4'b0000) begin
         bad++; $display("FAIL none_token got ready=%b gnt=%b want ready=1 gnt=0000", bus.in_ready, bus.gnt);
      end
      bus.in_none = 1'b0; bus.in_idx = 2'd1;
      tick();
      total++;
      if (bus.gnt !== 4'b0010) begin bad++; $display("FAIL none_then_grant got=%b want=0010", bus.gnt); end
      // Fresh requests while busy must not disturb the held grant.
      bus.in_idx = 2'd3;
      tick();
      total++;
      if (bus.gnt !== 4'b0010) begin bad++; $display("FAIL busy_ignore got=%b want=0010", bus.gnt); end
      bus.in_valid = 1'b0;
   endtask

   task automatic test_reset_mid();
      total++;
      if (bus.gnt !== 4'b0010) begin bad++; $display("FAIL pre_reset got=%b want=0010", bus.gnt); end
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      total++;
      if (bus.gnt !== 4'b0000 || bus.in_ready !== 1'b1) begin
         bad++; $display("FAIL async_reset got gnt=%b ready=%b want gnt=0000 ready=1", bus.gnt, bus.in_ready);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         int sel;
         bus.in_valid = ($urandom_range(0, 3) != 0);
         bus.in_none  = ($urandom_range(0, 4) == 0);
         bus.in_idx   = 2'($urandom_range(0, 3));
         sel = $urandom_range(0, 9);
         if (sel == 0)      bus.ack = exp_gnt();
         else if (sel == 1) bus.ack = 4'($urandom_range(0, 15));
         else               bus.ack = 4'b0000;
         tick();
         total++;
         if (bus.gnt !== exp_gnt() || bus.in_ready !== exp_ready() ||
             bus.busy !== !exp_ready() || bus.timeout_evt !== m_tevt) begin
            bad++;
            $display("FAIL rand_cycle%0d got gnt=%b rdy=%b busy=%b tevt=%b want gnt=%b rdy=%b busy=%b tevt=%b",
                     c, bus.gnt, bus.in_ready, bus.busy, bus.timeout_evt,
                     exp_gnt(), exp_ready(), !exp_ready(), m_tevt);
         end
      end
      idle_inputs();
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      model_reset();
      idle_inputs();
      test_reset();
      test_grant_ack();
      test_timeout();
      test_ack_mask();
      test_none_then_grant();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
